// File: rtl/encoder_pkg.sv
// Shared types for the round-robin request encoder.
package encoder_pkg;

    typedef enum logic {S_IDLE, S_HOLD} enc_state_t;

endpackage

// File: rtl/priority_encoder.sv
// Combinational LSB-first priority encoder: index of the lowest set request bit.
module priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] index,
    output logic                 any
);

    localparam int W = $clog2(N);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        any   = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_request_encoder.sv
// Round-robin request encoder: grants one asserted request line and
// presents its registered binary index and one-hot grant over a valid/ready handshake.
module rr_request_encoder
    import encoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N-1:0]         req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_index,
    output logic [N-1:0]         out_grant
);

    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    enc_state_t     state;
    enc_state_t     state_next;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_next;
    logic [W-1:0]   masked_index;
    logic [W-1:0]   raw_index;
    logic [W-1:0]   winner;
    logic [N-1:0]   mask;
    logic           masked_any;
    logic           raw_any;
    logic           accept;
    logic           capture;

    // The scan uses ptr_next so a back-to-back capture already sees the advanced pointer.
    always_comb begin
        accept     = (state == S_HOLD) && out_ready;
        ptr_next   = ptr;
        if (accept) begin
            ptr_next = (out_index == LAST) ? '0 : out_index + W'(1);
        end
        capture    = ena && (|req) && ((state == S_IDLE) || accept);
        state_next = state;
        if (capture) begin
            state_next = S_HOLD;
        end else if (accept) begin
            state_next = S_IDLE;
        end
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr_next));
        end
    end

    priority_encoder #(.N(N)) u_masked_enc (
        .req   (req & mask),
        .index (masked_index),
        .any   (masked_any)
    );

    priority_encoder #(.N(N)) u_raw_enc (
        .req   (req),
        .index (raw_index),
        .any   (raw_any)
    );

    // Nothing at or above ptr means the scan wraps to the lowest raw request.
    assign winner = masked_any ? masked_index : raw_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_grant <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (capture) begin
                out_valid <= 1'b1;
                out_index <= winner;
                out_grant <= {{(N - 1){1'b0}}, 1'b1} << winner;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_index <= '0;
                out_grant <= '0;
            end
        end
    end

    logic unused_raw_any;
    assign unused_raw_any = raw_any;

endmodule

// File: tb/tb_rr_request_encoder.sv
// Scoreboard bench for rr_request_encoder: directed scenarios plus a randomized soak.
module tb_rr_request_encoder;

    logic       clk = 1'b0;
    logic       rst, ena, out_ready, out_valid;
    logic [3:0] req, out_grant;
    logic [1:0] out_index;

    logic       rst3, ena3, ready3, valid3;
    logic [2:0] req3, grant3;
    logic [1:0] index3;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];
    int exp_q3[$];

    bit model_on = 1'b0;
    bit m_valid  = 1'b0;
    int m_ptr    = 0;
    int m_index  = 0;

    always #5 clk = ~clk;

    rr_request_encoder #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_grant (out_grant)
    );

    rr_request_encoder #(.N(3)) dut3 (
        .clk       (clk),
        .rst       (rst3),
        .ena       (ena3),
        .req       (req3),
        .out_valid (valid3),
        .out_ready (ready3),
        .out_index (index3),
        .out_grant (grant3)
    );

    task checkOutput(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: rotating scan from the pointer, used only in the random soak.
    task modelStep(input logic r, input logic e, input logic [3:0] q, input logic rdy);
        bit acc;
        if (r) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_index = 0;
            exp_q.delete();
            return;
        end
        acc = m_valid && rdy;
        if (acc) m_ptr = (m_index == 3) ? 0 : m_index + 1;
        if (e && (|q) && (!m_valid || acc)) begin
            for (int k = 3; k >= 0; k--) begin
                if (q[(m_ptr + k) % 4]) m_index = (m_ptr + k) % 4;
            end
            m_valid = 1'b1;
            exp_q.push_back(m_index);
        end else if (acc) begin
            m_valid = 1'b0;
            m_index = 0;
        end
    endtask

    task applyStimulus(input logic r, input logic e, input logic [3:0] q, input logic rdy);
        rst       = r;
        ena       = e;
        req       = q;
        out_ready = rdy;
        tick();
        if (model_on) modelStep(r, e, q, rdy);
    endtask

    bit         stalled = 1'b0;
    logic       sv_valid;
    logic [1:0] sv_index;
    logic [3:0] sv_grant;
    int         wait_cnt[4];

    // Monitor for the N=4 instance: inputs are stable from here to the next rising edge.
    always @(negedge clk) begin : mon4
        int e;
        checkOutput("grant_invariant", int'(out_grant), out_valid ? (1 << out_index) : 0);
        if (stalled) begin
            checkOutput("stall_valid", int'(out_valid), int'(sv_valid));
            checkOutput("stall_index", int'(out_index), int'(sv_index));
            checkOutput("stall_grant", int'(out_grant), int'(sv_grant));
        end
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_grant", int'(out_index), -1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("grant_index", int'(out_index), e);
                checkOutput("grant_onehot", int'(out_grant), 1 << e);
            end
            for (int i = 0; i < 4; i++) begin
                if (int'(out_index) == i) wait_cnt[i] = 0;
                else if (req[i]) wait_cnt[i]++;
                checkOutput("starvation", int'(wait_cnt[i] > 4), 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!req[i] || rst) wait_cnt[i] = 0;
        end
        stalled  = out_valid && !out_ready && !rst;
        sv_valid = out_valid;
        sv_index = out_index;
        sv_grant = out_grant;
    end

    always @(negedge clk) begin : mon3
        int e;
        if (!rst3) begin
            checkOutput("n3_invariant", int'(grant3), valid3 ? (1 << index3) : 0);
        end
        if (valid3 && ready3 && !rst3) begin
            if (exp_q3.size() == 0) begin
                checkOutput("n3_unexpected_grant", int'(index3), -1);
            end else begin
                e = exp_q3.pop_front();
                checkOutput("n3_grant_index", int'(index3), e);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        rst = 1'b1; ena = 1'b0; req = '0; out_ready = 1'b0;
        rst3 = 1'b1; ena3 = 1'b0; req3 = '0; ready3 = 1'b0;
        tick();
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_index", int'(out_index), 0);
        checkOutput("reset_grant", int'(out_grant), 0);

        // Two requesters alternate at full throughput.
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(3);
        repeat (4) applyStimulus(1'b0, 1'b1, 4'b1010, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        checkOutput("t1_idle_after", int'(out_valid), 0);
        checkOutput("t1_drain", exp_q.size(), 0);

        // A single pulse is held through a stall and released on accept.
        exp_q.push_back(0);
        applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("t2_hold_valid", int'(out_valid), 1);
            checkOutput("t2_hold_grant", int'(out_grant), 1);
            applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        checkOutput("t2_accept_valid", int'(out_valid), 0);
        checkOutput("t2_accept_grant", int'(out_grant), 0);
        checkOutput("t2_drain", exp_q.size(), 0);

        // Pointer is 1 here; reset during HOLD must drop the grant and the pointer.
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
        checkOutput("t5_hold_index", int'(out_index), 1);
        checkOutput("t5_hold_grant", int'(out_grant), 2);
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1);
        checkOutput("t5_rst_valid", int'(out_valid), 0);
        checkOutput("t5_rst_grant", int'(out_grant), 0);
        checkOutput("t5_rst_index", int'(out_index), 0);
        exp_q.push_back(0);
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        checkOutput("t5_drain", exp_q.size(), 0);

        // ena low blocks capture even with every line requesting.
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);
            checkOutput("t4_ena_low_valid", int'(out_valid), 0);
        end
        exp_q.push_back(0);
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
        checkOutput("t4_capture_valid", int'(out_valid), 1);
        checkOutput("t4_capture_index", int'(out_index), 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        checkOutput("t4_drain", exp_q.size(), 0);

        // Non-power-of-two instance must wrap at N-1.
        tick();
        rst3 = 1'b0;
        exp_q3.push_back(0); exp_q3.push_back(1); exp_q3.push_back(2); exp_q3.push_back(0);
        ena3 = 1'b1; req3 = 3'b111; ready3 = 1'b1;
        repeat (4) tick();
        ena3 = 1'b0;
        tick();
        checkOutput("t3_idle_after", int'(valid3), 0);
        checkOutput("t3_drain", exp_q3.size(), 0);

        // Randomized soak against the reference model.
        model_on = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        rq = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                          rq, $urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        checkOutput("t6_drain", exp_q.size(), 0);
        checkOutput("t6_final_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
